// File: rtl/sram_1rw_stream_ctrl.sv
// -----------------------------------------------------------------------------
// sram_1rw_stream_ctrl
// Banked single-port SRAM controller with lane-masked writes, a valid/ready
// request channel and a credit-protected, first-word-fall-through read
// response buffer. Reads return in order with latency 1+OUT_REG.
//
// Ports
//   clock         rising-edge clock
//   resetN        synchronous active-low reset (array contents are kept)
//   req_valid     request present
//   req_ready     request accepted on req_valid & req_ready
//   req_write     1 = write, 0 = read
//   req_addr      word address
//   req_mask      write lane enables, one bit per MASK_UNIT bits
//   req_dataIn    write data
//   resp_valid    read response present
//   resp_ready    consumer accepts the response
//   resp_dataOut  read data (0 for an out-of-range read)
//   resp_error    response belongs to an out-of-range read
//   busy          reads in flight or responses buffered
// -----------------------------------------------------------------------------
module sram_1rw_stream_ctrl #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_UNIT  = 8,
    parameter int MASK_WIDTH = DATA_WIDTH / MASK_UNIT,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_BANKS  = 2,
    parameter int OUT_REG    = 1,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [MASK_WIDTH-1:0] req_mask,
    input  logic [DATA_WIDTH-1:0] req_dataIn,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_dataOut,
    output logic                  resp_error,
    output logic                  busy
);

    localparam int ROWS   = (DEPTH + NUM_BANKS - 1) / NUM_BANKS;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(RESP_DEPTH);
    localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(RESP_DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_WIDTH does not wrap to zero
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  req_ready_r;
    logic                  busy_r;
    logic                  acc_s;
    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  in_range_s;
    logic [BANK_W-1:0]     bank_s;
    logic [ROW_W-1:0]      row_s;
    logic [DATA_WIDTH-1:0] bank_rdata_s [NUM_BANKS];

    logic                  s0_valid_r;
    logic                  s0_err_r;
    logic [BANK_W-1:0]     s0_bank_r;
    logic [DATA_WIDTH-1:0] s0_data_s;
    logic                  last_valid_s;
    logic                  last_err_s;
    logic [DATA_WIDTH-1:0] last_data_s;

    logic [DATA_WIDTH-1:0] fifo_data_r [RESP_DEPTH];
    logic                  fifo_err_r  [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      fifo_cnt_r;
    logic [CNT_W-1:0]      occ_r;
    logic [CNT_W-1:0]      occ_next_s;
    logic                  fifo_empty_s;
    logic                  pop_s;
    logic                  fifo_push_s;
    logic                  fifo_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_ONE;
        end
    endfunction

    // resetN gates acceptance so nothing presented during reset is taken
    assign acc_s      = req_valid & req_ready_r & resetN;
    assign in_range_s = ({1'b0, req_addr} < ADDR_LIMIT);
    assign rd_acc_s   = acc_s & ~req_write;
    assign wr_acc_s   = acc_s & req_write & in_range_s;
    assign bank_s     = BANK_W'(req_addr % ADDR_WIDTH'(NUM_BANKS));
    assign row_s      = ROW_W'(req_addr / ADDR_WIDTH'(NUM_BANKS));

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic en_s;
        // Out-of-range reads still take a credit but never touch a bank
        assign en_s = ((rd_acc_s & in_range_s) | wr_acc_s) & (bank_s == BANK_W'(b));
`ifdef ASIC_SRAM
        logic [DATA_WIDTH-1:0] bit_en_s;
        for (genvar i = 0; i < MASK_WIDTH; i++) begin : g_bit_en
            assign bit_en_s[i*MASK_UNIT +: MASK_UNIT] = {MASK_UNIT{req_mask[i]}};
        end
        sram_macro_1rw #(
            .WORDS (ROWS),
            .WIDTH (DATA_WIDTH)
        ) u_macro (
            .clk   (clock),
            .ce    (en_s),
            .we    (req_write),
            .addr  (row_s),
            .bwe   (bit_en_s),
            .wdata (req_dataIn),
            .rdata (bank_rdata_s[b])
        );
`else
        logic [DATA_WIDTH-1:0] mem_r [ROWS];
        logic [DATA_WIDTH-1:0] rdata_r;
        // Behavioural bank: lane-masked write or registered read, one access per cycle
        always_ff @(posedge clock) begin
            if (en_s) begin
                if (req_write) begin
                    for (int i = 0; i < MASK_WIDTH; i++) begin
                        if (req_mask[i]) begin
                            mem_r[row_s][i*MASK_UNIT +: MASK_UNIT] <= req_dataIn[i*MASK_UNIT +: MASK_UNIT];
                        end
                    end
                end else begin
                    rdata_r <= mem_r[row_s];
                end
            end
        end
        assign bank_rdata_s[b] = rdata_r;
`endif
    end

    // Stage 0 tags the bank output with validity, error flag and source bank
    always_ff @(posedge clock) begin
        if (!resetN) begin
            s0_valid_r <= 1'b0;
            s0_err_r   <= 1'b0;
            s0_bank_r  <= {BANK_W{1'b0}};
        end else begin
            s0_valid_r <= rd_acc_s;
            s0_err_r   <= ~in_range_s;
            s0_bank_r  <= bank_s;
        end
    end

    assign s0_data_s = s0_err_r ? {DATA_WIDTH{1'b0}} : bank_rdata_s[s0_bank_r];

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s1_valid_r;
        logic                  s1_err_r;
        logic [DATA_WIDTH-1:0] s1_data_r;
        // Optional output register after the array
        always_ff @(posedge clock) begin
            if (!resetN) begin
                s1_valid_r <= 1'b0;
                s1_err_r   <= 1'b0;
                s1_data_r  <= {DATA_WIDTH{1'b0}};
            end else begin
                s1_valid_r <= s0_valid_r;
                s1_err_r   <= s0_err_r;
                s1_data_r  <= s0_data_s;
            end
        end
        assign last_valid_s = s1_valid_r;
        assign last_err_s   = s1_err_r;
        assign last_data_s  = s1_data_r;
    end else begin : g_no_out_reg
        assign last_valid_s = s0_valid_r;
        assign last_err_s   = s0_err_r;
        assign last_data_s  = s0_data_s;
    end

    assign fifo_empty_s = (fifo_cnt_r == {CNT_W{1'b0}});

    // Response head: oldest buffered entry, else the pipeline output bypasses an empty FIFO
    always_comb begin
        resp_valid   = 1'b0;
        resp_dataOut = {DATA_WIDTH{1'b0}};
        resp_error   = 1'b0;
        if (!fifo_empty_s) begin
            resp_valid   = 1'b1;
            resp_dataOut = fifo_data_r[rd_ptr_r];
            resp_error   = fifo_err_r[rd_ptr_r];
        end else if (last_valid_s) begin
            resp_valid   = 1'b1;
            resp_dataOut = last_data_s;
            resp_error   = last_err_s;
        end else begin
            resp_valid   = 1'b0;
            resp_dataOut = {DATA_WIDTH{1'b0}};
            resp_error   = 1'b0;
        end
    end

    assign pop_s       = resp_valid & resp_ready;
    assign fifo_pop_s  = pop_s & ~fifo_empty_s;
    // A pipeline result consumed straight through the bypass is never buffered
    assign fifo_push_s = last_valid_s & ~(fifo_empty_s & resp_ready);

    // Next credit occupancy: +1 per accepted read, -1 per response handshake
    always_comb begin
        occ_next_s = occ_r;
        if (rd_acc_s && !pop_s) begin
            occ_next_s = occ_r + CNT_ONE;
        end else if (!rd_acc_s && pop_s) begin
            occ_next_s = occ_r - CNT_ONE;
        end else begin
            occ_next_s = occ_r;
        end
    end

    // Response FIFO storage; occupancy bounded by credits so it never overflows
    always_ff @(posedge clock) begin
        if (resetN && fifo_push_s) begin
            fifo_data_r[wr_ptr_r] <= last_data_s;
            fifo_err_r[wr_ptr_r]  <= last_err_s;
        end
    end

    // FIFO pointers, credit counter and the registered ready/busy outputs
    always_ff @(posedge clock) begin
        if (!resetN) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            fifo_cnt_r  <= {CNT_W{1'b0}};
            occ_r       <= {CNT_W{1'b0}};
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (fifo_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (fifo_push_s && !fifo_pop_s) begin
                fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
            end else if (!fifo_push_s && fifo_pop_s) begin
                fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
            end
            occ_r       <= occ_next_s;
            req_ready_r <= (occ_next_s < CNT_MAX);
            busy_r      <= (occ_next_s != {CNT_W{1'b0}});
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sram_1rw_stream_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sram_1rw_stream_ctrl (DEPTH=1000, 2 banks,
// OUT_REG=1, 4 credits). A word-array model with lane-masked writes and a
// queue of expected responses is updated on every observed handshake; every
// response popped by the consumer is compared in order.
// -----------------------------------------------------------------------------
module tb_sram_1rw_stream_ctrl;

    localparam int DEPTH = 1000;
    localparam int DW    = 64;
    localparam int MW    = 8;
    localparam int AW    = 10;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic          clock = 1'b0;
    logic          resetN;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [MW-1:0] req_mask;
    logic [DW-1:0] req_dataIn;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_dataOut;
    logic          resp_error;
    logic          busy;

    logic [DW-1:0] model_mem [DEPTH];
    exp_t          exp_q [$];
    int            acc_cyc_q [$];
    int            pop_cyc_q [$];
    int            cyc   = 0;
    int            n_cmp = 0;
    int            n_mis = 0;

    logic          s_acc;
    logic          s_req_ready;
    logic          s_resp_valid;
    logic          s_resp_error;
    logic [DW-1:0] s_resp_data;
    logic          s_busy;

    sram_1rw_stream_ctrl #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .MASK_UNIT  (8),
        .NUM_BANKS  (2),
        .OUT_REG    (1),
        .RESP_DEPTH (4)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_mask     (req_mask),
        .req_dataIn   (req_dataIn),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_dataOut (resp_dataOut),
        .resp_error   (resp_error),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, update model/scoreboard, return just after the rising edge
    task automatic tick();
        exp_t e;
        @(negedge clock);
        cyc++;
        s_req_ready  = req_ready;
        s_resp_valid = resp_valid;
        s_resp_error = resp_error;
        s_resp_data  = resp_dataOut;
        s_busy       = busy;
        s_acc        = req_valid & req_ready & resetN;
        if (resp_valid && resp_ready && resetN) begin
            pop_cyc_q.push_back(cyc);
            chk("resp_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("resp_data", resp_dataOut, e.data);
                chk("resp_error", 64'(resp_error), 64'(e.err));
            end
        end
        if (s_acc) begin
            acc_cyc_q.push_back(cyc);
            if (req_write) begin
                if (int'(req_addr) < DEPTH) begin
                    for (int i = 0; i < MW; i++) begin
                        if (req_mask[i]) model_mem[req_addr][i*8 +: 8] = req_dataIn[i*8 +: 8];
                    end
                end
            end else begin
                if (int'(req_addr) < DEPTH) begin
                    e.err  = 1'b0;
                    e.data = model_mem[req_addr];
                end else begin
                    e.err  = 1'b1;
                    e.data = 64'd0;
                end
                exp_q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] addr,
                          input logic [MW-1:0] mask, input logic [DW-1:0] data);
        int n = 0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_mask   = mask;
        req_dataIn = data;
        do begin
            tick();
            n++;
        end while (!s_acc && n < 200);
        if (!s_acc) chk("req_accept_timeout", 64'(s_acc), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        tick();
        chk("busy_idle", 64'(s_busy), 64'd0);
    endtask

    task automatic wait_resp();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!s_resp_valid && n < 20);
        chk("resp_wait", 64'(s_resp_valid), 64'd1);
    endtask

    initial begin
        int n_acc;
        resetN     = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_mask   = '0;
        req_dataIn = '0;
        resp_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_req_ready", 64'(s_req_ready), 64'd0);
        chk("rst_resp_valid", 64'(s_resp_valid), 64'd0);
        chk("rst_resp_error", 64'(s_resp_error), 64'd0);
        chk("rst_resp_data", s_resp_data, 64'd0);
        chk("rst_busy", 64'(s_busy), 64'd0);
        resetN = 1'b1;
        tick();
        tick();
        chk("ready_after_reset", 64'(s_req_ready), 64'd1);

        // Fill the whole array with random data
        for (int a = 0; a < DEPTH; a++) do_req(1'b1, AW'(a), 8'hFF, {$urandom, $urandom});
        req_valid = 1'b0;

        // Write then read addr 5, check exact latency
        do_req(1'b1, 10'd5, 8'hFF, 64'h1122334455667788);
        do_req(1'b0, 10'd5, 8'h00, 64'd0);
        req_valid = 1'b0;
        tick();
        chk("lat_cycle1_valid", 64'(s_resp_valid), 64'd0);
        tick();
        chk("lat_cycle2_valid", 64'(s_resp_valid), 64'd1);
        chk("rd5_data", s_resp_data, 64'h1122334455667788);
        chk("rd5_error", 64'(s_resp_error), 64'd0);
        drain();

        // Masked write to addr 6
        do_req(1'b1, 10'd6, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        do_req(1'b1, 10'd6, 8'h0F, 64'd0);
        do_req(1'b0, 10'd6, 8'h00, 64'd0);
        req_valid = 1'b0;
        wait_resp();
        chk("masked_data", s_resp_data, 64'hFFFF_FFFF_0000_0000);
        drain();

        // Credit limit under backpressure
        resp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = AW'(i);
            tick();
            if (s_acc) n_acc++;
        end
        req_valid = 1'b0;
        chk("credit_accepts", 64'(n_acc), 64'd4);
        chk("credit_ready_low", 64'(s_req_ready), 64'd0);
        repeat (3) tick();
        chk("credit_busy", 64'(s_busy), 64'd1);
        chk("hold_valid", 64'(s_resp_valid), 64'd1);
        chk("hold_data", s_resp_data, model_mem[0]);
        tick();
        chk("hold_data_later", s_resp_data, model_mem[0]);
        chk("hold_ready_still_low", 64'(s_req_ready), 64'd0);
        resp_ready = 1'b1;
        do_req(1'b0, 10'd4, 8'h00, 64'd0);
        do_req(1'b0, 10'd5, 8'h00, 64'd0);
        drain();

        // Streaming throughput: 100 reads, one per cycle
        acc_cyc_q.delete();
        pop_cyc_q.delete();
        for (int i = 0; i < 100; i++) do_req(1'b0, AW'(i), 8'h00, 64'd0);
        drain();
        chk("tp_accepts", 64'(acc_cyc_q.size()), 64'd100);
        chk("tp_resps", 64'(pop_cyc_q.size()), 64'd100);
        if (acc_cyc_q.size() == 100 && pop_cyc_q.size() == 100) begin
            chk("tp_accept_span", 64'(acc_cyc_q[99] - acc_cyc_q[0]), 64'd99);
            chk("tp_resp_span", 64'(pop_cyc_q[99] - pop_cyc_q[0]), 64'd99);
            chk("tp_first_latency", 64'(pop_cyc_q[0] - acc_cyc_q[0]), 64'd2);
        end

        // Out-of-range read and write
        do_req(1'b0, 10'd1010, 8'h00, 64'd0);
        req_valid = 1'b0;
        wait_resp();
        chk("oor_error", 64'(s_resp_error), 64'd1);
        chk("oor_data", s_resp_data, 64'd0);
        drain();
        do_req(1'b1, 10'd1010, 8'hFF, {$urandom, $urandom});
        for (int a = 0; a < DEPTH; a++) do_req(1'b0, AW'(a), 8'h00, 64'd0);
        drain();

        // Random traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_write  = 1'($urandom_range(0, 1));
            req_addr   = AW'($urandom_range(0, 1023));
            req_mask   = MW'($urandom);
            req_dataIn = {$urandom, $urandom};
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset with reads in flight and one buffered; a write presented during reset is ignored
        resp_ready = 1'b0;
        do_req(1'b0, 10'd10, 8'h00, 64'd0);
        req_valid = 1'b0;
        repeat (3) tick();
        do_req(1'b0, 10'd11, 8'h00, 64'd0);
        do_req(1'b0, 10'd12, 8'h00, 64'd0);
        resetN     = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 10'd7;
        req_mask   = 8'hFF;
        req_dataIn = ~model_mem[7];
        repeat (2) tick();
        exp_q.delete();
        chk("midrst_resp_valid", 64'(s_resp_valid), 64'd0);
        chk("midrst_busy", 64'(s_busy), 64'd0);
        chk("midrst_req_ready", 64'(s_req_ready), 64'd0);
        req_valid  = 1'b0;
        resetN     = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_resp", 64'(s_resp_valid), 64'd0);
        end
        do_req(1'b0, 10'd5, 8'h00, 64'd0);
        do_req(1'b0, 10'd6, 8'h00, 64'd0);
        do_req(1'b0, 10'd7, 8'h00, 64'd0);
        do_req(1'b0, 10'd10, 8'h00, 64'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
